// File: rtl/mem_dm_access_ctrl.sv
// MEM-stage data-memory access sequencer: alignment check, lane steering,
// req/ack handshake with timeout, load extension and fault merging.
module mem_dm_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  in_except,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] in_add,
  input  logic        full,
  input  logic        half,
  input  logic        byte_acc,
  input  logic        ld_unsigned,
  input  logic [31:0] st_data,
  input  logic        pipe_hold,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic [8:0]  out_except,
  output logic        dm_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  state_t            state_q, state_d;
  size_t             size_c, size_q;
  logic              misalign_c, mem_op_c, no_exc_c, acc_c, mis_fault_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, ld_ext_c;
  logic [1:0]        lane_q;
  logic              uns_q, load_q, we_q;
  logic [1:0]        fault_q;   // {load fault, store fault}
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;

  // Access size decode (full > half > byte, none means word) and launch qualification
  always_comb begin
    size_c = SZ_WORD;
    if (full)          size_c = SZ_WORD;
    else if (half)     size_c = SZ_HALF;
    else if (byte_acc) size_c = SZ_BYTE;
    misalign_c  = (full & (in_add[1:0] != 2'b00)) | (~full & half & in_add[0]);
    mem_op_c    = memread | memwrite;
    no_exc_c    = (in_except == 9'd0);
    acc_c       = mem_op_c & no_exc_c & ~misalign_c;
    mis_fault_c = mem_op_c & no_exc_c & misalign_c;
  end

  // Byte enables and lane-replicated store data for the launching access
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = st_data;
    unique case (size_c)
      SZ_BYTE: begin
        be_c    = 4'b0001 << in_add[1:0];
        wdata_c = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be_c    = in_add[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = st_data;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned read word
  always_comb begin
    ld_byte_c = dm_rdata[7:0];
    unique case (lane_q)
      2'd0:    ld_byte_c = dm_rdata[7:0];
      2'd1:    ld_byte_c = dm_rdata[15:8];
      2'd2:    ld_byte_c = dm_rdata[23:16];
      default: ld_byte_c = dm_rdata[31:24];
    endcase
    ld_half_c = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    unique case (size_q)
      SZ_BYTE: ld_ext_c = {{24{~uns_q & ld_byte_c[7]}}, ld_byte_c};
      SZ_HALF: ld_ext_c = {{16{~uns_q & ld_half_c[15]}}, ld_half_c};
      default: ld_ext_c = dm_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE never relaunches, so a held access cannot double issue
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (acc_c) state_d = S_REQ;
      S_REQ:  if (dm_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
      S_DONE: if (!pipe_hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake, stall and exception outputs
  always_comb begin
    dm_req     = 1'b0;
    stall      = 1'b0;
    out_except = in_except;
    unique case (state_q)
      S_IDLE: begin
        stall = acc_c;
        if (mis_fault_c) begin
          if (memread) out_except[2] = 1'b1;
          else         out_except[1] = 1'b1;
        end
      end
      S_REQ: begin
        dm_req = 1'b1;
        stall  = 1'b1;
      end
      S_DONE: begin
        out_except[2] = in_except[2] | fault_q[1];
        out_except[1] = in_except[1] | fault_q[0];
      end
      default: ;
    endcase
    dm_we = dm_req & we_q;
  end

  // Access latch, timeout counter, load result and fault capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_addr    <= 32'd0;
      dm_be      <= 4'd0;
      dm_wdata   <= 32'd0;
      ld_data    <= 32'd0;
      dm_timeout <= 1'b0;
      size_q     <= SZ_WORD;
      lane_q     <= 2'd0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      fault_q    <= 2'd0;
      cnt_q      <= '0;
    end else begin
      dm_timeout <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (acc_c) begin
            dm_addr  <= {in_add[31:2], 2'b00};
            dm_be    <= be_c;
            dm_wdata <= wdata_c;
            size_q   <= size_c;
            lane_q   <= in_add[1:0];
            uns_q    <= ld_unsigned;
            load_q   <= memread;
            we_q     <= memwrite & ~memread;
            fault_q  <= 2'd0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dm_ack) begin
            if (load_q) ld_data <= ld_ext_c;
          end else if (cnt_q == CNT_LAST) begin
            dm_timeout <= 1'b1;
            fault_q    <= load_q ? 2'b10 : 2'b01;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dm_access_ctrl.sv
// Bench for mem_dm_access_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference of lanes, extension and timing.
module tb_mem_dm_access_ctrl;

  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned CNT_W       = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  in_except;
  logic        memread, memwrite;
  logic [31:0] in_add;
  logic        full, half, byte_acc, ld_unsigned;
  logic [31:0] st_data;
  logic        pipe_hold;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        stall;
  logic [8:0]  out_except;
  logic        dm_timeout;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ld = 32'd0;
  bit          ld_known = 1'b1;

  mem_dm_access_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_except(in_except), .memread(memread),
    .memwrite(memwrite), .in_add(in_add), .full(full), .half(half),
    .byte_acc(byte_acc), .ld_unsigned(ld_unsigned), .st_data(st_data),
    .pipe_hold(pipe_hold), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ld_data(ld_data), .stall(stall), .out_except(out_except),
    .dm_timeout(dm_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    memread = 1'b0; memwrite = 1'b0; in_except = 9'd0; in_add = 32'd0;
    full = 1'b0; half = 1'b0; byte_acc = 1'b0; ld_unsigned = 1'b0;
    st_data = 32'd0; pipe_hold = 1'b0; dm_ack = 1'b0; dm_rdata = 32'd0;
  endtask

  // sz: 0 byte, 1 half, 2 word via full, 3 word via no size bit.
  // ack_at: REQ cycle (1-based) carrying dm_ack; beyond TIMEOUT_CYC means never.
  task automatic do_access(input bit is_load, input logic [31:0] addr, input int sz,
                           input bit uns, input logic [31:0] sdata, input logic [31:0] rdata,
                           input int ack_at, input int hold, input string tag);
    int          l, n_req;
    bit          mis, tmo;
    logic [31:0] exp_be, exp_wd, exp_ld, v;
    logic [8:0]  exp_exc;
    l   = int'(addr[1:0]);
    mis = (sz == 2 && l != 0) || (sz == 1 && (l % 2) != 0);
    memread = is_load; memwrite = !is_load; in_add = addr; st_data = sdata;
    ld_unsigned = uns; in_except = 9'd0;
    full     = (sz == 2);
    half     = (sz == 1) || (sz == 2 && 1'($urandom_range(0, 1)));
    byte_acc = (sz == 0) || ((sz == 1 || sz == 2) && 1'($urandom_range(0, 1)));
    #1;
    if (mis) begin
      exp_exc = is_load ? 9'h004 : 9'h002;
      check({tag, ":mis_stall"}, 32'(stall), 32'd0);
      check({tag, ":mis_req"}, 32'(dm_req), 32'd0);
      check({tag, ":mis_exc"}, 32'(out_except), 32'(exp_exc));
      tick();
      check({tag, ":mis_req_next"}, 32'(dm_req), 32'd0);
      drive_idle();
      return;
    end
    exp_be = (sz == 0) ? (32'd1 << l) : (sz == 1) ? (32'd3 << (2 * (l / 2))) : 32'd15;
    exp_wd = (sz == 0) ? 32'(sdata[7:0]) * 32'h01010101 :
             (sz == 1) ? 32'(sdata[15:0]) * 32'h00010001 : sdata;
    if (sz == 0) begin
      v = (rdata >> (8 * l)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (rdata >> (16 * (l / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    exp_ld = v;
    tmo   = (ack_at > int'(TIMEOUT_CYC));
    n_req = tmo ? int'(TIMEOUT_CYC) : ack_at;
    check({tag, ":launch_stall"}, 32'(stall), 32'd1);
    check({tag, ":launch_req"}, 32'(dm_req), 32'd0);
    for (int c = 1; c <= n_req; c++) begin
      tick();
      dm_ack   = (c == ack_at);
      dm_rdata = (c == ack_at) ? rdata : $urandom;
      #1;
      check({tag, ":req"}, 32'(dm_req), 32'd1);
      check({tag, ":req_stall"}, 32'(stall), 32'd1);
      if (c == 1 || c == n_req) begin
        check({tag, ":addr"}, dm_addr, addr & 32'hFFFFFFFC);
        check({tag, ":be"}, 32'(dm_be), exp_be);
        check({tag, ":we"}, 32'(dm_we), 32'(!is_load));
        if (!is_load) check({tag, ":wdata"}, dm_wdata, exp_wd);
        check({tag, ":req_exc"}, 32'(out_except), 32'd0);
      end
    end
    tick();
    dm_ack = 1'b0;
    if (!tmo) begin
      if (is_load) begin model_ld = exp_ld; ld_known = 1'b1; end
      else         ld_known = 1'b0;
    end
    exp_exc   = tmo ? (is_load ? 9'h004 : 9'h002) : 9'h000;
    pipe_hold = (hold > 0);
    #1;
    check({tag, ":done_stall"}, 32'(stall), 32'd0);
    check({tag, ":done_req"}, 32'(dm_req), 32'd0);
    check({tag, ":done_tmo"}, 32'(dm_timeout), 32'(tmo));
    check({tag, ":done_exc"}, 32'(out_except), 32'(exp_exc));
    if (ld_known) check({tag, ":ld_data"}, ld_data, model_ld);
    for (int h = 0; h < hold; h++) begin
      tick();
      pipe_hold = (h + 1 < hold);
      dm_ack    = 1'b1;
      dm_rdata  = $urandom;
      #1;
      check({tag, ":hold_req"}, 32'(dm_req), 32'd0);
      check({tag, ":hold_stall"}, 32'(stall), 32'd0);
      check({tag, ":hold_tmo"}, 32'(dm_timeout), 32'd0);
      check({tag, ":hold_exc"}, 32'(out_except), 32'(exp_exc));
      if (ld_known) check({tag, ":hold_ld"}, ld_data, model_ld);
    end
    tick();
    drive_idle();
    #1;
    check({tag, ":idle_req"}, 32'(dm_req), 32'd0);
    check({tag, ":idle_stall"}, 32'(stall), 32'd0);
    check({tag, ":idle_exc"}, 32'(out_except), 32'd0);
  endtask

  initial begin
    logic [8:0] exc;
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_we", 32'(dm_we), 32'd0);
    check("rst_be", 32'(dm_be), 32'd0);
    check("rst_tmo", 32'(dm_timeout), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ld", ld_data, 32'd0);
    check("rst_wdata", dm_wdata, 32'd0);
    check("rst_addr", dm_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    do_access(1'b1, 32'h100, 3, 1'b0, 32'd0, 32'hDEADBEEF, 3, 0, "word_ld");
    check("word_ld_val", ld_data, 32'hDEADBEEF);
    do_access(1'b0, 32'h203, 0, 1'b0, 32'h000000A5, 32'd0, 2, 0, "byte_st");
    do_access(1'b1, 32'h1001, 1, 1'b0, 32'd0, 32'd0, 1, 0, "half_mis");
    do_access(1'b0, 32'h402, 2, 1'b0, 32'd0, 32'd0, 1, 0, "full_mis");
    do_access(1'b1, 32'h302, 0, 1'b0, 32'd0, 32'h00800000, 1, 0, "sbyte_ld");
    check("sbyte_val", ld_data, 32'hFFFFFF80);
    do_access(1'b1, 32'h302, 0, 1'b1, 32'd0, 32'h00800000, 2, 0, "ubyte_ld");
    check("ubyte_val", ld_data, 32'h00000080);
    do_access(1'b1, 32'h306, 1, 1'b0, 32'd0, 32'h8001_1234, 1, 0, "shalf_ld");
    check("shalf_val", ld_data, 32'hFFFF8001);
    do_access(1'b0, 32'h400, 2, 1'b0, 32'h12345678, 32'd0, TIMEOUT_CYC + 5, 0, "st_tmo");
    do_access(1'b1, 32'h404, 3, 1'b0, 32'd0, 32'h0BADF00D, TIMEOUT_CYC, 0, "ack_at_limit");
    do_access(1'b1, 32'h408, 2, 1'b0, 32'd0, 32'h5A5A1234, 2, 2, "hold2");

    // Exception from an earlier stage suppresses the access
    exc = 9'h1A0;
    memread = 1'b1; full = 1'b1; in_add = 32'h600; in_except = exc;
    #1;
    check("exc_stall", 32'(stall), 32'd0);
    check("exc_pass", 32'(out_except), 32'(exc));
    tick();
    check("exc_req", 32'(dm_req), 32'd0);
    drive_idle();

    // Stray ack with no request outstanding
    dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
    tick();
    check("stray_req", 32'(dm_req), 32'd0);
    check("stray_tmo", 32'(dm_timeout), 32'd0);
    check("stray_ld", ld_data, model_ld);
    drive_idle();

    // Reset while a request is outstanding
    memread = 1'b1; full = 1'b1; in_add = 32'h500;
    tick();
    tick();
    check("midrst_req_before", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    drive_idle();
    tick();
    check("midrst_req", 32'(dm_req), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_ld", ld_data, 32'd0);
    check("midrst_be", 32'(dm_be), 32'd0);
    model_ld = 32'd0; ld_known = 1'b1;
    rst_n = 1'b1;
    tick();
    check("postrst_req", 32'(dm_req), 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(1, 6), $urandom_range(0, 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
